// File: rtl/jts16_mapper_gen.sv
// Programmable 68000 address mapper: region decode, wait states, sound latches, VBLANK IRQ.
// Optional status dump port enabled by defining JTS16_MAPPER_STDUMP_EN.
module jts16_mapper_gen #(
    parameter int REGIONS = 8,
    parameter int WAITW   = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cpu_cen,
    input  logic [23:1]        addr,
    input  logic [15:0]        cpu_dout,
    input  logic [1:0]         cpu_dsn,
    input  logic               cpu_rnw,
    input  logic               cpu_asn,
    input  logic [2:0]         cpu_fc,
    output logic [15:0]        cpu_din,
    output logic               cpu_dtackn,
    output logic [2:0]         cpu_ipln,
    input  logic               edackn,
    input  logic               bus_busy,
    output logic [REGIONS-1:0] active,
    output logic               reg_cs,
    input  logic               vint,
    input  logic               snd_rd,
    input  logic               snd_wr,
    input  logic [7:0]         snd_din,
    output logic [7:0]         snd_dout,
    output logic               snd_obf,
    output logic               main_ibf,
    input  logic [7:0]         st_addr,
    output logic [7:0]         st_dout
);

    localparam int RBW = $clog2(REGIONS);
    localparam int RW  = RBW + 2;

    localparam logic [RW-2:0] IDX_SND_OUT = (RW-1)'(0);
    localparam logic [RW-2:0] IDX_IRQ     = (RW-1)'(1);
    localparam logic [RW-2:0] IDX_SND_IN  = (RW-1)'(2);
    localparam logic [RW-2:0] IDX_STATUS  = (RW-1)'(3);

    typedef logic [7:0] byte_t;

    byte_t            sizew_q [REGIONS];
    byte_t            sizew_d [REGIONS];
    byte_t            base_q  [REGIONS];
    byte_t            base_d  [REGIONS];
    byte_t            snd_out_q, snd_out_d;
    byte_t            irq_ctrl_q, irq_ctrl_d;
    byte_t            snd_in_q, snd_in_d;
    logic             snd_obf_q, snd_obf_d;
    logic             main_ibf_q, main_ibf_d;
    logic             irq_pend_q, irq_pend_d;
    logic             vint_q, vint_d;
    logic             acc_done_q, acc_done_d;
    logic             armed_q, armed_d;
    logic             busy_q, busy_d;
    logic             bypass_q, bypass_d;
    logic [WAITW-1:0] wcnt_q, wcnt_d;

    logic [REGIONS-1:0] rmatch;
    logic [REGIONS-1:0] active_c;
    logic               hit_any;
    logic [WAITW-1:0]   sel_wait;
    logic [RW-1:0]      idx;
    logic               write_fire;
    logic               read_fire;
    logic [2:0]         irq_lvl;

    assign idx     = addr[RW:1];
    assign irq_lvl = irq_ctrl_q[3:1];

    function automatic byte_t reg_read(input logic [RW-1:0] i);
        byte_t v;
        v = '0;
        if (i[RW-1]) begin
            v = i[0] ? base_q[i[RW-2:1]] : sizew_q[i[RW-2:1]];
        end else if (i[RW-2:0] == IDX_SND_OUT) begin
            v = snd_out_q;
        end else if (i[RW-2:0] == IDX_IRQ) begin
            v = irq_ctrl_q;
        end else if (i[RW-2:0] == IDX_SND_IN) begin
            v = snd_in_q;
        end else if (i[RW-2:0] == IDX_STATUS) begin
            v = {6'b0, main_ibf_q, snd_obf_q};
        end
        return v;
    endfunction

    always_comb begin
        rmatch = '0;
        for (int unsigned r = 0; r < REGIONS; r++) begin
            case (sizew_q[r][1:0])
                2'd0:    rmatch[r] = (addr[23:16] == base_q[r]);
                2'd1:    rmatch[r] = (addr[23:17] == base_q[r][7:1]);
                2'd2:    rmatch[r] = (addr[23:19] == base_q[r][7:3]);
                default: rmatch[r] = (addr[23:21] == base_q[r][7:5]);
            endcase
        end
    end

    always_comb begin
        active_c = '0;
        hit_any  = 1'b0;
        sel_wait = '0;
        for (int unsigned r = 0; r < REGIONS; r++) begin
            if (rmatch[r] && !hit_any) begin
                hit_any     = 1'b1;
                active_c[r] = 1'b1;
                sel_wait    = sizew_q[r][WAITW+1:2];
            end
        end
        if (cpu_fc == 3'b111) begin
            active_c = '0;
            hit_any  = 1'b0;
            sel_wait = '0;
        end
    end

    assign active     = active_c;
    assign reg_cs     = !hit_any && (cpu_fc != 3'b111) && !cpu_asn;
    assign write_fire = reg_cs && !cpu_rnw && !cpu_dsn[0] && !acc_done_q;
    assign read_fire  = reg_cs && cpu_rnw && !acc_done_q;
    assign cpu_din    = (reg_cs && cpu_rnw) ? {8'hFF, reg_read(idx)} : 16'hFFFF;

    always_comb begin
        sizew_d    = sizew_q;
        base_d     = base_q;
        snd_out_d  = snd_out_q;
        irq_ctrl_d = irq_ctrl_q;
        snd_in_d   = snd_in_q;
        snd_obf_d  = snd_obf_q;
        main_ibf_d = main_ibf_q;
        irq_pend_d = irq_pend_q;
        vint_d     = vint;
        acc_done_d = acc_done_q;
        armed_d    = armed_q;
        busy_d     = busy_q;
        bypass_d   = bypass_q;
        wcnt_d     = wcnt_q;

        // One register access per bus cycle; the flag rearms when AS# rises.
        if (cpu_asn)
            acc_done_d = 1'b0;
        else if (write_fire || read_fire)
            acc_done_d = 1'b1;

        if (snd_rd)
            snd_obf_d = 1'b0;
        if (read_fire && !idx[RW-1] && idx[RW-2:0] == IDX_SND_IN)
            main_ibf_d = 1'b0;

        if (write_fire) begin
            if (idx[RW-1]) begin
                if (idx[0])
                    base_d[idx[RW-2:1]] = cpu_dout[7:0];
                else
                    sizew_d[idx[RW-2:1]] = cpu_dout[7:0];
            end else if (idx[RW-2:0] == IDX_SND_OUT) begin
                snd_out_d = cpu_dout[7:0];
                snd_obf_d = 1'b1;
            end else if (idx[RW-2:0] == IDX_IRQ) begin
                irq_ctrl_d = cpu_dout[7:0];
            end
        end

        if (snd_wr) begin
            snd_in_d   = snd_din;
            main_ibf_d = 1'b1;
        end

        if (cpu_fc == 3'b111 && !cpu_asn)
            irq_pend_d = 1'b0;
        if (vint && !vint_q && irq_ctrl_q[0])
            irq_pend_d = 1'b1;

        // armed_q requires AS# seen high, so a cycle cut by reset cannot restart.
        if (cpu_asn) begin
            armed_d = 1'b1;
            busy_d  = 1'b0;
        end else if (cpu_cen && armed_q) begin
            armed_d  = 1'b0;
            busy_d   = 1'b1;
            wcnt_d   = hit_any ? sel_wait : WAITW'(1);
            bypass_d = hit_any && (sel_wait == '1);
        end else if (cpu_cen && busy_q && wcnt_q != '0 && !bus_busy) begin
            wcnt_d = wcnt_q - WAITW'(1);
        end
    end

    always_comb begin
        cpu_dtackn = 1'b1;
        if (busy_q && !cpu_asn) begin
            if (bypass_q)
                cpu_dtackn = edackn;
            else
                cpu_dtackn = !(wcnt_q == '0 && !bus_busy);
        end
    end

    assign cpu_ipln = (irq_pend_q && irq_lvl != 3'd0) ? ~irq_lvl : 3'b111;
    assign snd_dout = snd_out_q;
    assign snd_obf  = snd_obf_q;
    assign main_ibf = main_ibf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < REGIONS; r++) begin
                sizew_q[r] <= '0;
                base_q[r]  <= '0;
            end
            snd_out_q  <= '0;
            irq_ctrl_q <= '0;
            snd_in_q   <= '0;
            snd_obf_q  <= 1'b0;
            main_ibf_q <= 1'b0;
            irq_pend_q <= 1'b0;
            vint_q     <= 1'b0;
            acc_done_q <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            bypass_q   <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            sizew_q    <= sizew_d;
            base_q     <= base_d;
            snd_out_q  <= snd_out_d;
            irq_ctrl_q <= irq_ctrl_d;
            snd_in_q   <= snd_in_d;
            snd_obf_q  <= snd_obf_d;
            main_ibf_q <= main_ibf_d;
            irq_pend_q <= irq_pend_d;
            vint_q     <= vint_d;
            acc_done_q <= acc_done_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            bypass_q   <= bypass_d;
            wcnt_q     <= wcnt_d;
        end
    end

`ifdef JTS16_MAPPER_STDUMP_EN
    logic [7:0]    st_dout_q, st_dout_d;
    logic [RW-1:0] st_idx;

    always_comb begin
        st_idx    = st_addr[7] ? RW'(st_addr[1:0]) : {1'b1, st_addr[RW-2:0]};
        st_dout_d = reg_read(st_idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            st_dout_q <= '0;
        else
            st_dout_q <= st_dout_d;
    end

    assign st_dout = st_dout_q;
`else
    assign st_dout = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{addr[15:RW+1], cpu_dout[15:8], cpu_dsn[1], st_addr};

endmodule
